mem_access: RTL

Memory-access stage of the rv32i pipeline, sitting directly downstream of the ALU stage and upstream of writeback. It consumes the ALU stage's clock-enable / stall / flush handshake, issues load and store transactions on a single-master request/acknowledge data bus, and aligns and extends load data. It forwards every result to writeback, including non-memory results, with a register-write qualifier.

---
 rtl/mem_access_pkg.sv | 79 +++++++
 rtl/mem_access_load_align.sv | 31 +++
 rtl/mem_access.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the rv32i memory-access stage.
//   - One-hot opcode class bit indices and OPCODE_WIDTH.
//   - Named load/store funct3 encodings (LS_B .. LS_HU).
//   - FSM state type, store byte-lane struct and the helpers that build
//     store lanes and detect misaligned accesses.
package mem_access_pkg;

    localparam int OPCODE_WIDTH = 11;

    // One-hot opcode class bit positions.
    localparam int R_TYPE = 0;
    localparam int I_TYPE = 1;
    localparam int L_TYPE = 2;
    localparam int S_TYPE = 3;
    localparam int B_TYPE = 4;
    localparam int JAL    = 5;
    localparam int JALR   = 6;
    localparam int LUI    = 7;
    localparam int AUIPC  = 8;
    localparam int SYSTEM = 9;
    localparam int FENCE  = 10;

    // Load/store size and sign encodings.
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // Classes that write a destination register.
    localparam logic [OPCODE_WIDTH-1:0] WR_RD_MASK = OPCODE_WIDTH'(
        (1 << R_TYPE) | (1 << I_TYPE) | (1 << L_TYPE) | (1 << JAL) |
        (1 << JALR) | (1 << LUI) | (1 << AUIPC));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] data;
    } store_lane_t;

    // Byte enables and replicated write data for a store. Halfwords key
    // off addr[1] only, words ignore the offset entirely.
    function automatic store_lane_t store_lane(input logic [2:0]  funct3,
                                               input logic [1:0]  offset,
                                               input logic [31:0] rs2);
        store_lane_t s;
        s.sel  = 4'b1111;
        s.data = rs2;
        case (funct3[1:0])
            2'b00: begin
                s.sel  = 4'b0001 << offset;
                s.data = {4{rs2[7:0]}};
            end
            2'b01: begin
                s.sel  = 4'b0011 << {offset[1], 1'b0};
                s.data = {2{rs2[15:0]}};
            end
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3,
                                        input logic [1:0] offset);
        logic m;
        case (funct3[1:0])
            2'b01:   m = offset[0];
            2'b10:   m = |offset;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// load_align: combinational load data alignment and extension.
//   data   : raw 32-bit bus read word
//   offset : byte offset of the access within the word
//   funct3 : load size/sign (LS_B, LS_H, LS_W, LS_BU, LS_HU)
//   result : selected byte/halfword, sign- or zero-extended to 32 bits
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? data[31:16] : data[15:0];
        result   = data;
        case (funct3)
            LS_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LS_H:    result = {{16{half_sel[15]}}, half_sel};
            LS_BU:   result = {24'd0, byte_sel};
            LS_HU:   result = {16'd0, half_sel};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: rv32i memory-access stage.
// Takes instructions from the ALU stage (i_ce/i_stall/i_flush handshake),
// runs loads and stores on a single-master cyc/stb/ack data bus, aligns and
// extends load data and forwards every result to writeback with o_wr_rd.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   i_ce .. i_pc        : instruction from the ALU stage
//   i_flush, i_stall    : drop incoming instruction / writeback backpressure
//   o_stall             : backpressure toward the ALU stage (combinational)
//   o_ce .. o_misaligned: result toward writeback
//   o_wb_*, i_wb_*      : data bus master
// Build option: define MISALIGN_TRAP_EN to turn misaligned halfword/word
// accesses into a 1-cycle faulting result instead of a bus cycle.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_ce,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic [2:0]              i_funct3,
    input  logic [31:0]             i_rd,
    input  logic [31:0]             i_rs2,
    input  logic [4:0]              i_rd_addr,
    input  logic [31:0]             i_pc,
    input  logic                    i_flush,
    input  logic                    i_stall,
    output logic                    o_stall,
    output logic                    o_ce,
    output logic [OPCODE_WIDTH-1:0] o_opcode,
    output logic [31:0]             o_pc,
    output logic [4:0]              o_rd_addr,
    output logic [31:0]             o_rd,
    output logic                    o_wr_rd,
    output logic                    o_misaligned,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [ADDR_WIDTH-1:0]   o_wb_addr,
    output logic [31:0]             o_wb_data,
    output logic [3:0]              o_wb_sel,
    input  logic                    i_wb_ack,
    input  logic [31:0]             i_wb_data
);

    state_t      state, next_state;
    logic        is_load, is_store, is_mem;
    logic        accept, trap, wr_rd;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic [31:0] load_data;
    store_lane_t lane;

    assign is_load  = i_opcode[L_TYPE];
    assign is_store = i_opcode[S_TYPE];
    assign is_mem   = is_load || is_store;
    assign accept   = (state == IDLE) && i_ce && !i_flush && !i_stall;
    assign wr_rd    = (|(i_opcode & WR_RD_MASK)) && (i_rd_addr != 5'd0);
    assign lane     = store_lane(i_funct3, i_rd[1:0], i_rs2);

`ifdef MISALIGN_TRAP_EN
    assign trap = is_mem && misaligned(i_funct3, i_rd[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Anything past IDLE is an instruction still in flight, so upstream waits.
    assign o_stall  = i_stall || (state != IDLE);
    assign o_wb_cyc = (state == BUSY);
    assign o_wb_stb = (state == BUSY);

    load_align u_load_align (
        .data   (i_wb_data),
        .offset (off_q),
        .funct3 (funct3_q),
        .result (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept && is_mem && !trap) next_state = BUSY;
            BUSY: if (i_wb_ack) next_state = i_stall ? HOLD : IDLE;
            HOLD: if (!i_stall) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_ce         <= 1'b0;
            o_opcode     <= '0;
            o_pc         <= '0;
            o_rd_addr    <= '0;
            o_rd         <= '0;
            o_wr_rd      <= 1'b0;
            o_misaligned <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_addr    <= '0;
            o_wb_data    <= '0;
            o_wb_sel     <= '0;
            off_q        <= '0;
            funct3_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_opcode     <= i_opcode;
                        o_pc         <= i_pc;
                        o_rd_addr    <= i_rd_addr;
                        o_misaligned <= trap;
                        o_wr_rd      <= wr_rd && !trap;
                        if (is_mem && !trap) begin
                            o_ce      <= 1'b0;
                            o_wb_we   <= is_store;
                            o_wb_addr <= {i_rd[ADDR_WIDTH-1:2], 2'b00};
                            o_wb_sel  <= is_store ? lane.sel : 4'b0000;
                            o_wb_data <= is_store ? lane.data : 32'd0;
                            off_q     <= i_rd[1:0];
                            funct3_q  <= i_funct3;
                        end else begin
                            // Non-memory result, or faulting address on a trap.
                            o_ce <= 1'b1;
                            o_rd <= i_rd;
                        end
                    end else if (!i_stall) begin
                        o_ce <= 1'b0;
                    end
                end
                BUSY: begin
                    if (i_wb_ack) begin
                        o_rd <= o_wb_we ? 32'd0 : load_data;
                        o_ce <= !i_stall;
                    end
                end
                HOLD: begin
                    if (!i_stall) o_ce <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
